// File: rtl/cpu_defs.sv
// Shared fetch-stage constants: reset/handler vectors, instruction memory
// window, exception codes and the nop encoding.
// Imported by if_pc_unit and if_id_reg; holds no logic of its own.
package cpu_defs;

  localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush.
// Latency: 1 cycle. Reset and flush clear every field; hold freezes all fields.
// Ports: clk, reset, flush, hold, *_in (F-stage values), *_D (registered values).
module if_id_reg
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  output logic [31:0] ir_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        bd_D,
  output logic [4:0]  exc_D
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ir_D  <= NOP;
      pc_D  <= 32'h0;
      pc4_D <= 32'h0;
      bd_D  <= 1'b0;
      exc_D <= EXC_NONE;
    end else if (!hold) begin
      ir_D  <= ir_in;
      pc_D  <= pc_in;
      pc4_D <= pc4_in;
      bd_D  <= bd_in;
      exc_D <= exc_in;
    end
  end

endmodule

// File: rtl/if_pc_unit.sv
// Fetch PC register, next-PC selection (exception/eret/stall/redirect/+4),
// fetch address-error detection and the IF/ID register feeding the D stage.
// Ports: clk/reset, stall, change/pc_new, branch_D, exc_req, eret/epc, instr_F
// in; imem_addr, pc_F, ir_D, pc_D, pc4_D, bd_D, exc_D out.
module if_pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter logic [31:0] PC_HANDLER = PC_HANDLER_DEF,
  parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
  parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        change,
  input  logic [31:0] pc_new,
  input  logic        branch_D,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr_F,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_F,
  output logic [31:0] ir_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        bd_D,
  output logic [4:0]  exc_D
);

  logic [31:0] pc4_F;
  logic [31:0] pc_next;
  logic        adel_F;
  logic [31:0] ir_F;
  logic [4:0]  exc_F;

  assign imem_addr = pc_F;
  assign pc4_F     = pc_F + 32'd4;   // wraps silently at 2^32

  assign adel_F = (pc_F[1:0] != 2'b00) || (pc_F < IMEM_LO) || (pc_F > IMEM_HI);
  // A faulting fetch is replaced by a nop but keeps its PC for EPC.
  assign ir_F   = adel_F ? NOP : instr_F;
  assign exc_F  = adel_F ? EXC_ADEL : EXC_NONE;

  // Exception beats eret, both beat stall; stall drops a concurrent redirect
  // because ID re-asserts it once the pipeline moves again.
  always_comb begin
    pc_next = pc4_F;
    if (exc_req)     pc_next = PC_HANDLER;
    else if (eret)   pc_next = epc;
    else if (stall)  pc_next = pc_F;
    else if (change) pc_next = pc_new;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_F <= PC_RESET;
    else       pc_F <= pc_next;
  end

  // A redirect is not a flush: the instruction fetched alongside it is the
  // delay slot and is loaded normally.
  if_id_reg u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .flush  (exc_req || eret),
    .hold   (stall),
    .ir_in  (ir_F),
    .pc_in  (pc_F),
    .pc4_in (pc4_F),
    .bd_in  (branch_D),
    .exc_in (exc_F),
    .ir_D   (ir_D),
    .pc_D   (pc_D),
    .pc4_D  (pc4_D),
    .bd_D   (bd_D),
    .exc_D  (exc_D)
  );

endmodule

// File: tb/tb_if_pc_unit.sv
// Bench for if_pc_unit: directed vector table covering the fetch corner
// cases, then randomized cycles checked against a behavioural model.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, change, branch_D, exc_req, eret;
  logic [31:0] pc_new, epc, instr_F;
  logic [31:0] imem_addr, pc_F, ir_D, pc_D, pc4_D;
  logic        bd_D;
  logic [4:0]  exc_D;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: a distinct nonzero word per address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign instr_F = memw(imem_addr);

  if_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .change(change), .pc_new(pc_new),
    .branch_D(branch_D), .exc_req(exc_req), .eret(eret), .epc(epc),
    .instr_F(instr_F), .imem_addr(imem_addr), .pc_F(pc_F), .ir_D(ir_D),
    .pc_D(pc_D), .pc4_D(pc4_D), .bd_D(bd_D), .exc_D(exc_D)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stl, chg;
    logic [31:0] pcn;
    logic        brd, exc, ert;
    logic [31:0] ep;
    logic [31:0] e_pcf, e_pcd, e_pc4, e_ir;
    logic        e_bd;
    logic [4:0]  e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic r, input logic s, input logic c, input logic [31:0] pn,
                       input logic b, input logic x, input logic e, input logic [31:0] ep);
    reset = r; stall = s; change = c; pc_new = pn;
    branch_D = b; exc_req = x; eret = e; epc = ep;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                           input logic [31:0] e_pc4, input logic [31:0] e_ir,
                           input logic e_bd, input logic [4:0] e_exc);
    check({tag, ".pc_F"},      pc_F,          e_pcf);
    check({tag, ".imem_addr"}, imem_addr,     e_pcf);
    check({tag, ".pc_D"},      pc_D,          e_pcd);
    check({tag, ".pc4_D"},     pc4_D,         e_pc4);
    check({tag, ".ir_D"},      ir_D,          e_ir);
    check({tag, ".bd_D"},      {31'h0, bd_D}, {31'h0, e_bd});
    check({tag, ".exc_D"},     {27'h0, exc_D}, {27'h0, e_exc});
  endtask

  // Behavioural model state.
  logic [31:0] m_pc, m_ir, m_pcd, m_pc4;
  logic        m_bd;
  logic [4:0]  m_exc;

  function automatic bit bad_fetch(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic c, input logic [31:0] pn,
                            input logic b, input logic x, input logic e, input logic [31:0] ep);
    logic [31:0] cur;
    cur = m_pc;
    if (r || x || e) begin
      {m_ir, m_pcd, m_pc4, m_bd, m_exc} = '0;
    end else if (!s) begin
      m_pcd = cur;
      m_pc4 = cur + 4;
      m_bd  = b;
      m_ir  = bad_fetch(cur) ? 32'h0 : memw(cur);
      m_exc = bad_fetch(cur) ? 5'd4 : 5'd0;
    end
    if (r)      m_pc = 32'h3000;
    else if (x) m_pc = 32'h4180;
    else if (e) m_pc = ep;
    else if (s) m_pc = cur;
    else if (c) m_pc = pn;
    else        m_pc = cur + 4;
  endtask

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 32'h3000 + ($urandom_range(0, 4095) << 2);
    else if (sel == 7) return 32'h3000 + $urandom_range(0, 16383);
    else if (sel == 8) return 32'h6FF0 + ($urandom_range(0, 7) << 2);
    else               return $urandom;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //           rst stl chg pc_new        brd exc ert epc           pc_F          pc_D          pc4_D         ir_D                bd exc
    vecs.push_back('{1, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h3000,     32'h0,        32'h0,        32'h0,              0, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h3004,     32'h3000,     32'h3004,     memw(32'h3000),     0, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h3008,     32'h3004,     32'h3008,     memw(32'h3004),     0, 5'd0});
    vecs.push_back('{0, 0, 1, 32'h3100,    1, 0, 0, 32'h0,       32'h3100,     32'h3008,     32'h300C,     memw(32'h3008),     1, 5'd0});
    vecs.push_back('{0, 1, 1, 32'h3200,    0, 0, 0, 32'h0,       32'h3100,     32'h3008,     32'h300C,     memw(32'h3008),     1, 5'd0});
    vecs.push_back('{0, 1, 1, 32'h3200,    0, 0, 0, 32'h0,       32'h3100,     32'h3008,     32'h300C,     memw(32'h3008),     1, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h3104,     32'h3100,     32'h3104,     memw(32'h3100),     0, 5'd0});
    vecs.push_back('{0, 1, 1, 32'h3300,    1, 1, 1, 32'h3010,    32'h4180,     32'h0,        32'h0,        32'h0,              0, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h4184,     32'h4180,     32'h4184,     memw(32'h4180),     0, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 1, 32'h3010,    32'h3010,     32'h0,        32'h0,        32'h0,              0, 5'd0});
    vecs.push_back('{0, 0, 1, 32'h3002,    0, 0, 0, 32'h0,       32'h3002,     32'h3010,     32'h3014,     memw(32'h3010),     0, 5'd0});
    vecs.push_back('{0, 0, 1, 32'h7000,    0, 0, 0, 32'h0,       32'h7000,     32'h3002,     32'h3006,     32'h0,              0, 5'd4});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h7004,     32'h7000,     32'h7004,     32'h0,              0, 5'd4});
    vecs.push_back('{0, 0, 1, 32'h6FFC,    0, 0, 0, 32'h0,       32'h6FFC,     32'h7004,     32'h7008,     32'h0,              0, 5'd4});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h7000,     32'h6FFC,     32'h7000,     memw(32'h6FFC),     0, 5'd0});
    vecs.push_back('{0, 0, 1, 32'h2FFC,    0, 0, 0, 32'h0,       32'h2FFC,     32'h7000,     32'h7004,     32'h0,              0, 5'd4});
    vecs.push_back('{0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h3000,     32'h2FFC,     32'h3000,     32'h0,              0, 5'd4});
    vecs.push_back('{0, 0, 1, 32'hFFFFFFFC,0, 0, 0, 32'h0,       32'hFFFFFFFC, 32'h3000,     32'h3004,     memw(32'h3000),     0, 5'd0});
    vecs.push_back('{0, 0, 0, 32'h0,       1, 0, 0, 32'h0,       32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,              1, 5'd4});
    vecs.push_back('{1, 1, 1, 32'h5000,    1, 1, 1, 32'h5000,    32'h3000,     32'h0,        32'h0,        32'h0,              0, 5'd0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].chg, vecs[i].pcn,
            vecs[i].brd, vecs[i].exc, vecs[i].ert, vecs[i].ep);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_pcd,
                vecs[i].e_pc4, vecs[i].e_ir, vecs[i].e_bd, vecs[i].e_exc);
    end

    // Hand sequence: stall released while ID still requests a redirect.
    drive(0, 1, 1, 32'h3400, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("seq.stall_hold_pc", pc_F, 32'h3000);
    drive(0, 0, 1, 32'h3400, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("seq.redirect_after_stall", pc_F, 32'h3400);
    check("seq.slot_pc", pc_D, 32'h3000);
    check("seq.slot_bd", {31'h0, bd_D}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("seq.target_in_D", pc_D, 32'h3400);

    // Randomized cycles against the model, starting from reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 2000; n++) begin
      logic r, s, c, b, x, e;
      logic [31:0] pn, ep;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 20);
      c  = ($urandom_range(0, 99) < 30);
      b  = $urandom_range(0, 1);
      x  = ($urandom_range(0, 99) < 4);
      e  = ($urandom_range(0, 99) < 4);
      pn = rand_target();
      ep = rand_target();
      drive(r, s, c, pn, b, x, e, ep);
      model_step(r, s, c, pn, b, x, e, ep);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_pcd, m_pc4, m_ir, m_bd, m_exc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pc_unit.md
# if_pc_unit

Fetch-stage program-counter and IF/ID pipeline register: the consumer of the ID-stage next-PC redirect (`change`/`pc_new`). Holds the fetch PC, advances it by 4, applies branch/jump/jr redirects, exception entry and `eret` returns from CP0, and detects fetch address errors. It registers the fetched instruction, PC, PC+4, delay-slot flag and exception code into the D stage.

## Interface
Parameters
- `PC_RESET`, 32'h0000_3000, PC value after reset
- `PC_HANDLER`, 32'h0000_4180, exception/interrupt entry address
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address
- `IMEM_HI`, 32'h0000_6FFC, highest legal fetch address

Ports
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hazard stall: hold PC and IF/ID
- `change`  in  1  ID-stage redirect request
- `pc_new`  in  32  redirect target from ID
- `branch_D`  in  1  instruction currently in D is a branch/jump (marks F instruction as delay slot)
- `exc_req`  in  1  CP0 takes exception/interrupt this cycle
- `eret`  in  1  `eret` committing this cycle
- `epc`  in  32  CP0 EPC return address
- `instr_F`  in  32  instruction word read at `imem_addr`
- `imem_addr`  out  32  equals `pc_F` (combinational)
- `pc_F`  out  32  current fetch PC
- `ir_D`, `pc_D`, `pc4_D`  out  32 each  IF/ID instruction, PC, PC+4
- `bd_D`  out  1  D instruction is in a delay slot
- `exc_D`  out  5  D exception code (0 none, 4 AdEL)

## Operation
- Next-PC priority, highest first: `reset` → `PC_RESET`; `exc_req` → `PC_HANDLER`; `eret` → `epc`; `stall` → hold; `change` → `pc_new`; else `pc_F + 4` (mod 2^32, wraps silently).
- IF/ID update, same priority: `reset`/`exc_req`/`eret` → flush (all D outputs 0); `stall` → hold; else load `ir_D`, `pc_D = pc_F`, `pc4_D = pc_F + 4`, `bd_D = branch_D`, `exc_D`.
- Fetch error: `adel_F = pc_F[1:0] != 0 || pc_F < IMEM_LO || pc_F > IMEM_HI`. If set, `ir_D` loads 32'h0 (nop), `exc_D = 4`, `pc_D` still the faulting PC.
- Redirect is not a flush: the F instruction fetched during a `change` cycle is the delay slot and is kept.
- `stall` with `change`: stall wins; redirect is dropped (ID re-asserts when unstalled).
- `exc_req` with `eret`: exception wins. `exc_req` overrides `stall`.

## Timing
- Reset: `pc_F = PC_RESET`; `ir_D`, `pc_D`, `pc4_D` = 0; `bd_D` = 0; `exc_D` = 0.
- Redirect/exception/eret asserted in cycle n → `pc_F` shows target at n+1; D shows target's fetch at n+2.
- IF→D latency 1 cycle. `imem_addr` has zero latency from `pc_F`.
- Reset mid-operation overrides every other input in that cycle.

## Structure
- Shared package `cpu_defs`: `PC_RESET`, `PC_HANDLER`, `IMEM_LO`, `IMEM_HI`, exception codes (`EXC_NONE=0`, `EXC_ADEL=4`), `NOP=32'h0`.
- One sub-module: `if_id_reg` (IF/ID register with hold and flush); next-PC mux, adder and AdEL check in the top.

## Test plan
- Reset, then 3 free-run cycles → `pc_F` 0x3000, 0x3004, 0x3008; `pc_D` lags by one, `pc4_D = pc_D + 4`.
- `change=1, pc_new=0x3100, branch_D=1` at `pc_F=0x3008` → next `pc_F=0x3100`; D holds 0x3008 with `bd_D=1`, not flushed.
- `stall=1` for 2 cycles with `change=1` → `pc_F` and all D outputs frozen; redirect not taken.
- `exc_req=1` with `stall=1` and `eret=1` → next `pc_F=0x4180`, D flushed to zeros.
- `eret=1, epc=0x3010` → next `pc_F=0x3010`, D flushed.
- Redirect to 0x3002, then to 0x7000 → each yields `ir_D=0`, `exc_D=4`, `pc_D` equal to the faulting address; `pc_F` continues +4.
